// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder slice plus a carry flop, LSB first, valid/ready on both sides.
// Result valid WIDTH cycles after acceptance; a result stalled in DONE blocks new operands.
module serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             carry_o,
  output logic             overflow_o
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] sa_q, sb_q, sum_q;
  logic [CW-1:0]    cnt_q;
  logic             c_q;
  logic             in_ready_q, out_valid_q, carry_q, overflow_q;

  logic             s_d, c_d;
  logic [WIDTH-1:0] sa_d;

  assign s_d  = sa_q[0] ^ sb_q[0] ^ c_q;
  assign c_d  = (sa_q[0] & sb_q[0]) | (sa_q[0] & c_q) | (sb_q[0] & c_q);
  // Sum bits backfill the MSBs vacated in SA, so SA doubles as the sum shift register.
  assign sa_d = {s_d, sa_q[WIDTH-1:1]};

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= IDLE;
      sa_q        <= '0;
      sb_q        <= '0;
      c_q         <= 1'b0;
      cnt_q       <= '0;
      sum_q       <= '0;
      carry_q     <= 1'b0;
      overflow_q  <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid_i) begin
            sa_q       <= a_i;
            sb_q       <= b_i;
            c_q        <= cin_i;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= RUN;
          end
        end
        RUN: begin
          sa_q  <= sa_d;
          sb_q  <= {1'b0, sb_q[WIDTH-1:1]};
          c_q   <= c_d;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == LAST_BIT) begin
            // c_q is the carry into the MSB, c_d the carry out of it.
            sum_q       <= sa_d;
            carry_q     <= c_d;
            overflow_q  <= c_q ^ c_d;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (out_ready_i) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = out_valid_q;
  assign sum_o       = sum_q;
  assign carry_o     = carry_q;
  assign overflow_o  = overflow_q;

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: directed cases plus a randomized stream against an arithmetic model.
module tb_serial_adder;
  localparam int W = 16;
  localparam int TMO = 200;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic         cin = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         in_ready, out_valid, carry, ovf;
  logic [W-1:0] sum;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(W)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .a_i(a), .b_i(b), .cin_i(cin),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .sum_o(sum), .carry_o(carry), .overflow_o(ovf)
  );

  // {overflow, carry, sum} from plain integer addition and sign rules.
  function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    logic [W:0] t;
    logic       v;
    t = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
    v = (x[W-1] == y[W-1]) && (t[W-1] != x[W-1]);
    return {v, t};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic c, output int waited);
    waited = 0;
    in_valid = 1'b1; a = x; b = y; cin = c;
    while (!in_ready && waited < TMO) begin step(); waited++; end
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < TMO) begin step(); lat++; end
  endtask

  task automatic consume();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #3;
    checks++;
    if ({in_ready, out_valid, carry, ovf, sum} !== {1'b1, 1'b0, 1'b0, 1'b0, {W{1'b0}}}) begin
      failures++;
      $display("FAIL reset_state got rdy=%b vld=%b c=%b v=%b sum=%h exp rdy=1 vld=0 c=0 v=0 sum=0",
               in_ready, out_valid, carry, ovf, sum);
    end
    #12 rst_n = 1'b1;
    repeat (3) step();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL idle_hold got vld=%b rdy=%b exp vld=0 rdy=1", out_valid, in_ready);
    end
  endtask

  task automatic test_basic();
    int w, lat;
    send(16'h0003, 16'h0005, 1'b0, w);
    wait_valid(lat);
    checks++;
    if (lat !== W) begin failures++; $display("FAIL basic_latency got=%0d exp=%0d", lat, W); end
    checks++;
    if ({ovf, carry, sum} !== {1'b0, 1'b0, 16'h0008}) begin
      failures++;
      $display("FAIL basic_sum got v=%b c=%b sum=%h exp v=0 c=0 sum=0008", ovf, carry, sum);
    end
    consume();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL basic_release got vld=%b rdy=%b exp vld=0 rdy=1", out_valid, in_ready);
    end
  endtask

  task automatic test_carry_overflow();
    logic [W-1:0] ta [2] = '{16'hFFFF, 16'h7FFF};
    logic [W-1:0] tb [2] = '{16'h0001, 16'h0001};
    logic [W+1:0] te [2] = '{{1'b0, 1'b1, 16'h0000}, {1'b1, 1'b0, 16'h8000}};
    int w, lat;
    for (int i = 0; i < 2; i++) begin
      send(ta[i], tb[i], 1'b0, w);
      wait_valid(lat);
      checks++;
      if ({ovf, carry, sum} !== te[i]) begin
        failures++;
        $display("FAIL carry_ovf[%0d] got=%h exp=%h", i, {ovf, carry, sum}, te[i]);
      end
      consume();
    end
  endtask

  task automatic test_backpressure();
    int w, lat;
    send(16'h8000, 16'h8000, 1'b1, w);
    wait_valid(lat);
    for (int i = 0; i < 10; i++) begin
      checks++;
      if ({out_valid, in_ready, ovf, carry, sum} !== {1'b1, 1'b0, 1'b1, 1'b1, 16'h0001}) begin
        failures++;
        $display("FAIL stall[%0d] got vld=%b rdy=%b v=%b c=%b sum=%h exp vld=1 rdy=0 v=1 c=1 sum=0001",
                 i, out_valid, in_ready, ovf, carry, sum);
      end
      step();
    end
    consume();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL stall_release got vld=%b rdy=%b exp vld=0 rdy=1", out_valid, in_ready);
    end
  endtask

  task automatic test_input_ignored();
    int w, lat;
    send(16'h1234, 16'h4321, 1'b0, w);
    step();
    in_valid = 1'b1; a = 16'h0001; b = 16'h0002; cin = 1'b0;
    step();
    checks++;
    if (in_ready !== 1'b0) begin failures++; $display("FAIL run_ready got=%b exp=0", in_ready); end
    wait_valid(lat);
    checks++;
    if ({ovf, carry, sum} !== {1'b0, 1'b0, 16'h5555}) begin
      failures++;
      $display("FAIL ignore_sum got v=%b c=%b sum=%h exp v=0 c=0 sum=5555", ovf, carry, sum);
    end
    consume();
    step();
    in_valid = 1'b0;
    wait_valid(lat);
    checks++;
    if (lat !== W || sum !== 16'h0003) begin
      failures++;
      $display("FAIL second_op got lat=%0d sum=%h exp lat=%0d sum=0003", lat, sum, W);
    end
    consume();
  endtask

  task automatic test_mid_reset();
    int w, lat;
    send(16'hAAAA, 16'h5555, 1'b1, w);
    repeat (7) step();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({in_ready, out_valid, carry, ovf, sum} !== {1'b1, 1'b0, 1'b0, 1'b0, {W{1'b0}}}) begin
      failures++;
      $display("FAIL midreset got rdy=%b vld=%b c=%b v=%b sum=%h exp rdy=1 vld=0 c=0 v=0 sum=0",
               in_ready, out_valid, carry, ovf, sum);
    end
    #13 rst_n = 1'b1;
    step();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL post_reset got rdy=%b vld=%b exp rdy=1 vld=0", in_ready, out_valid);
    end
    send(16'h00FF, 16'h0001, 1'b0, w);
    wait_valid(lat);
    checks++;
    if (lat !== W || {ovf, carry, sum} !== {1'b0, 1'b0, 16'h0100}) begin
      failures++;
      $display("FAIL fresh_op got lat=%0d sum=%h c=%b v=%b exp lat=%0d sum=0100 c=0 v=0", lat, sum, carry, ovf, W);
    end
    consume();
  endtask

  task automatic test_back_to_back();
    logic [W+1:0] q[$];
    logic [W+1:0] exp_r, held;
    logic [W-1:0] x, y;
    logic         c;
    int w, lat, got;
    got = 0;
    for (int i = 0; i < 1000; i++) begin
      x = W'($urandom); y = W'($urandom); c = 1'($urandom_range(0, 1));
      send(x, y, c, w);
      q.push_back(model(x, y, c));
      wait_valid(lat);
      checks++;
      if (w >= TMO || lat !== W) begin
        failures++;
        $display("FAIL b2b_timing[%0d] got wait=%0d lat=%0d exp wait<%0d lat=%0d", i, w, lat, TMO, W);
        break;
      end
      exp_r = q.pop_front();
      got++;
      checks++;
      if ({ovf, carry, sum} !== exp_r) begin
        failures++;
        $display("FAIL b2b_result[%0d] a=%h b=%h cin=%b got=%h exp=%h", i, x, y, c, {ovf, carry, sum}, exp_r);
      end
      held = {ovf, carry, sum};
      repeat ($urandom_range(0, 3)) step();
      checks++;
      if (out_valid !== 1'b1 || {ovf, carry, sum} !== held) begin
        failures++;
        $display("FAIL b2b_hold[%0d] got vld=%b res=%h exp vld=1 res=%h", i, out_valid, {ovf, carry, sum}, held);
      end
      consume();
      checks++;
      if (out_valid !== 1'b0) begin failures++; $display("FAIL b2b_dup[%0d] got vld=%b exp=0", i, out_valid); end
    end
    checks++;
    if (got !== 1000 || q.size() !== 0) begin
      failures++;
      $display("FAIL b2b_count got=%0d pending=%0d exp=1000 pending=0", got, q.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_carry_overflow();
    test_backpressure();
    test_input_ignored();
    test_mid_reset();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial multi-bit adder built around a single half-adder pair (sum bit plus carry-majority) and a carry flip-flop.
- Processes one bit per clock, LSB first.
- Sits between operand producers, such as the register file or a sequencer, and a result consumer. It trades latency for area compared with the combinational ripple chain.
- Operands enter through a valid/ready handshake. Results leave through a second valid/ready handshake.

Parameters:
WIDTH, 16, operand/result width in bits; legal range 2..64

Ports:
clk_i  input  1  clock; all state updates on rising edge
rst_n_i  input  1  asynchronous, active-low reset
in_valid_i  input  1  operands a_i/b_i/cin_i are valid
in_ready_o  output  1  block can accept operands
a_i  input  WIDTH  operand A (unsigned or two's complement)
b_i  input  WIDTH  operand B
cin_i  input  1  carry-in
out_valid_o  output  1  sum_o/carry_o/overflow_o are valid
out_ready_i  input  1  consumer accepts result
sum_o  output  WIDTH  (A + B + cin) mod 2^WIDTH
carry_o  output  1  carry out of bit WIDTH-1
overflow_o  output  1  signed overflow: carry into MSB XOR carry out of MSB

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low (rst_n_i). Asserting rst_n_i low at any time, including mid-operation, immediately forces:
  - state = IDLE, in_ready_o=1, out_valid_o=0;
  - sum_o=0, carry_o=0, overflow_o=0;
  - operand shift registers, carry register and bit counter = 0.
  The partial result is discarded. Operation resumes on the first rising edge after deassertion.
- State machine: IDLE, RUN, DONE.
- IDLE:
  - in_ready_o=1, out_valid_o=0.
  - On an edge with in_valid_i=1: latch a_i into shift register SA, b_i into SB, cin_i into carry register C, clear counter and sum register; go to RUN.
  - in_valid_i=0: stay.
- RUN:
  - in_ready_o=0, out_valid_o=0.
  - Each edge computes s = SA[0]^SB[0]^C and c' = majority(SA[0],SB[0],C).
  - Shift the sum register right, inserting s at bit WIDTH-1. Shift SA and SB right by 1. C <= c'. Counter increments.
  - On the edge where the counter reaches WIDTH-1 (the last bit), record the carry into the MSB (C before update) and C after update for overflow, then go to DONE.
- DONE:
  - out_valid_o=1, in_ready_o=0.
  - sum_o, carry_o and overflow_o are held stable and do not change until the handshake completes.
  - On an edge with out_ready_i=1: go to IDLE; out_valid_o drops the next cycle.
  - out_ready_i low: hold indefinitely (backpressure).
- Latency and throughput:
  - Acceptance edge T. Bits are processed on edges T+1..T+WIDTH. out_valid_o is high after edge T+WIDTH.
  - Minimum cycle between successive acceptances is WIDTH+2 (no overlap of output and input handshakes).
- Output registers: sum_o is visible only in DONE; it is 0 outside DONE after reset. After a result is consumed, sum_o/carry_o/overflow_o may hold stale values outside DONE; the consumer must qualify them with out_valid_o.
- Input changes: a_i/b_i/cin_i changes while not in IDLE are ignored. in_valid_i held high during RUN/DONE has no effect.
- Counter: width clog2(WIDTH)+1. There is no wrap within a single operation.

Test Plan:
1. Reset, then a=0x0003, b=0x0005, cin=0, WIDTH=16 -> out_valid_o rises exactly 16 cycles after the acceptance edge; sum_o=0x0008, carry_o=0, overflow_o=0.
2. a=0xFFFF, b=0x0001, cin=0 -> sum_o=0x0000, carry_o=1, overflow_o=0. Then a=0x7FFF, b=0x0001 -> sum_o=0x8000, carry_o=0, overflow_o=1.
3. a=0x8000, b=0x8000, cin=1 -> sum_o=0x0001, carry_o=1, overflow_o=1. Hold out_ready_i=0 for 10 cycles -> outputs stable and in_ready_o=0 throughout. Assert out_ready_i -> IDLE next cycle.
4. Change a_i/b_i and pulse in_valid_i during RUN -> result unaffected (0x1234+0x4321 -> 0x5555); the second operation is accepted only after returning to IDLE.
5. Pull rst_n_i low at bit 7 of an operation -> all outputs go to 0 immediately and in_ready_o=1 after release. A fresh 0x00FF+0x0001 -> 0x0100.
6. Back-to-back random operand streams (1000 vectors) with random out_ready_i stalls -> every result equals the reference sum; no result is lost or duplicated.
